// File: rtl/instr_register_pkg.sv
// Shared types for the instr_register and its write/read controller.
// Declares the instruction payload types plus the controller depth and pointer width.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    localparam int IR_NUM_ENTRIES = 32;
    localparam int IR_ADDR_W      = 5;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } ir_req_t;

endpackage

// File: rtl/instr_register_ctrl_if.sv
// Bus between the instr_register controller and its requesters, consumer and register file.
// The slave modport is the controller side; master is the requester/consumer side.
interface instr_register_ctrl_if;
    import instr_register_pkg::*;

    logic [1:0]           req_i;
    opcode_t              opcode_i    [2];
    operand_t             operand_a_i [2];
    operand_t             operand_b_i [2];
    logic [1:0]           gnt_o;

    logic                 load_en;
    logic [IR_ADDR_W-1:0] write_pointer;
    opcode_t              opcode;
    operand_t             operand_a;
    operand_t             operand_b;

    logic [IR_ADDR_W-1:0] read_pointer;
    logic                 rd_valid_o;
    logic                 rd_ready_i;
    logic [IR_ADDR_W:0]   count_o;
    logic                 full_o;
    logic                 empty_o;

    modport slave (
        input  req_i, opcode_i, operand_a_i, operand_b_i, rd_ready_i,
        output gnt_o, load_en, write_pointer, opcode, operand_a, operand_b,
        output read_pointer, rd_valid_o, count_o, full_o, empty_o
    );

    modport master (
        output req_i, opcode_i, operand_a_i, operand_b_i, rd_ready_i,
        input  gnt_o, load_en, write_pointer, opcode, operand_a, operand_b,
        input  read_pointer, rd_valid_o, count_o, full_o, empty_o
    );

endinterface

// File: rtl/ir_rr_arbiter.sv
// Two-way round-robin arbiter for the single instr_register write port.
// last_grant starts at requester 1 so requester 0 wins the first contention.
module ir_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_block,
    output logic [1:0] o_gnt
);

    logic       r_last_grant;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (!i_block) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_last_grant ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign o_gnt = w_gnt;

    // A grant is only ever issued to an active requester, so any grant is a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (|w_gnt) begin
            r_last_grant <= w_gnt[1];
        end
    end

endmodule

// File: rtl/instr_register_ctrl.sv
// Write arbitration, staging and circular-queue pointer control for the 32-entry instr_register.
// Optional macro IR_CTRL_FLUSH_EN adds flush_i, which drops the staged entry and empties the queue.
module instr_register_ctrl
    import instr_register_pkg::*;
#(
    parameter int NUM_ENTRIES = IR_NUM_ENTRIES,
    parameter int ADDR_W      = IR_ADDR_W
) (
    input  logic clk,
    input  logic reset_n,
`ifdef IR_CTRL_FLUSH_EN
    input  logic flush_i,
`endif
    instr_register_ctrl_if.slave bus
);

    localparam logic [ADDR_W+1:0] LP_FULL      = (ADDR_W+2)'(NUM_ENTRIES);
    localparam logic [ADDR_W:0]   LP_COUNT_MAX = (ADDR_W+1)'(NUM_ENTRIES);

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_stage_valid;
    ir_req_t           r_stage;

    logic [1:0]        w_gnt;
    logic              w_block;
    logic              w_xfer;
    logic              w_commit;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    ir_req_t           w_sel;

    // The staged entry counts toward occupancy so a grant can never overfill the register.
    assign w_full   = ({1'b0, r_count} + (ADDR_W+2)'(r_stage_valid)) == LP_FULL;
    assign w_empty  = (r_count == '0);
    assign w_commit = r_stage_valid;
    assign w_pop    = bus.rd_ready_i & ~w_empty;
    assign w_xfer   = |(bus.req_i & w_gnt);

`ifdef IR_CTRL_FLUSH_EN
    assign w_block = w_full | ~reset_n | flush_i;
`else
    assign w_block = w_full | ~reset_n;
`endif

    ir_rr_arbiter u_arb (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_req   (bus.req_i),
        .i_block (w_block),
        .o_gnt   (w_gnt)
    );

    always_comb begin
        w_sel.opc  = bus.opcode_i[0];
        w_sel.op_a = bus.operand_a_i[0];
        w_sel.op_b = bus.operand_b_i[0];
        if (w_gnt[1]) begin
            w_sel.opc  = bus.opcode_i[1];
            w_sel.op_a = bus.operand_a_i[1];
            w_sel.op_b = bus.operand_b_i[1];
        end
    end

    // Staging doubles as the write-data register; commit happens the edge after capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage_valid <= 1'b0;
            r_stage       <= '{opc: ZERO, op_a: '0, op_b: '0};
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else
`ifdef IR_CTRL_FLUSH_EN
        if (flush_i) begin
            r_stage_valid <= 1'b0;
            r_rptr        <= r_wptr;
            r_count       <= '0;
        end else
`endif
        begin
            r_stage_valid <= w_xfer;
            if (w_xfer) begin
                r_stage <= w_sel;
            end
            if (w_commit) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_commit, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.gnt_o         = w_gnt;
    assign bus.load_en       = r_stage_valid;
    assign bus.write_pointer = r_wptr;
    assign bus.opcode        = r_stage.opc;
    assign bus.operand_a     = r_stage.op_a;
    assign bus.operand_b     = r_stage.op_b;
    assign bus.read_pointer  = r_rptr;
    assign bus.rd_valid_o    = ~w_empty;
    assign bus.count_o       = r_count;
    assign bus.full_o        = w_full;
    assign bus.empty_o       = w_empty;

    a_count_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_commit && !w_pop && r_count == LP_COUNT_MAX));

endmodule
